// File: rtl/cfu_pkg.sv
// Shared definitions for the CFU scan initiator: default function ids and
// the controller state encoding.
package cfu_pkg;

    localparam logic [9:0] CFU_FID_INIT  = 10'd1;
    localparam logic [9:0] CFU_FID_QUERY = 10'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_CMD,
        S_INIT_RSP,
        S_Q_CMD,
        S_Q_RSP,
        S_EMIT
    } state_t;

endpackage

// File: rtl/cfu_scan_initiator.sv
// CPU-side driver of the CFU command/response bus: one init command carrying
// the box size, then one query per raster grid point, one result per point.
module cfu_scan_initiator
    import cfu_pkg::*;
#(
    parameter int         CNT_W     = 16,
    parameter logic [9:0] FID_INIT  = CFU_FID_INIT,
    parameter logic [9:0] FID_QUERY = CFU_FID_QUERY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          box_w,
    input  logic [31:0]          box_h,
    input  logic [31:0]          org_x,
    input  logic [31:0]          org_y,
    input  logic [CNT_W-1:0]     cols,
    input  logic [CNT_W-1:0]     rows,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [9:0]           cmd_payload_function_id,
    output logic [31:0]          cmd_payload_inputs_0,
    output logic [31:0]          cmd_payload_inputs_1,
    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    input  logic [31:0]          rsp_payload_outputs_0,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_x,
    output logic [31:0]          res_y,
    output logic                 res_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*CNT_W-1:0]   hit_count
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_xi;
    logic [CNT_W-1:0]   r_yi;
    logic [CNT_W-1:0]   r_cols;
    logic [CNT_W-1:0]   r_rows;
    logic [31:0]        r_box_w;
    logic [31:0]        r_box_h;
    logic [31:0]        r_org_x;
    logic [31:0]        r_org_y;
    logic               r_res_in;
    logic               r_done;
    logic [2*CNT_W-1:0] r_hit_count;

    logic        w_start;
    logic        w_empty;
    logic        w_last;
    logic        w_row_end;
    logic        w_capture;
    logic        w_advance;
    logic        w_finish;
    logic [31:0] w_qx;
    logic [31:0] w_qy;
    logic        w_rsp_unused;

    assign w_start   = (r_state == S_IDLE) && start;
    assign w_empty   = (r_cols == '0) || (r_rows == '0);
    assign w_row_end = (r_xi == r_cols - CNT_W'(1));
    assign w_last    = w_row_end && (r_yi == r_rows - CNT_W'(1));
    assign w_qx      = r_org_x + 32'(r_xi);
    assign w_qy      = r_org_y + 32'(r_yi);
    // Only bit 0 of a query response carries the inside/outside answer.
    assign w_rsp_unused = ^rsp_payload_outputs_0[31:1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        w_next                  = r_state;
        cmd_valid               = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0    = '0;
        cmd_payload_inputs_1    = '0;
        rsp_ready               = 1'b0;
        res_valid               = 1'b0;
        w_capture               = 1'b0;
        w_advance               = 1'b0;
        w_finish                = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_INIT_CMD;
            end
            S_INIT_CMD: begin
                cmd_valid               = 1'b1;
                cmd_payload_function_id = FID_INIT;
                cmd_payload_inputs_0    = r_box_w;
                cmd_payload_inputs_1    = r_box_h;
                rsp_ready               = 1'b1;
                if (cmd_ready) begin
                    if (!rsp_valid) begin
                        w_next = S_INIT_RSP;
                    end else if (w_empty) begin
                        w_next   = S_IDLE;
                        w_finish = 1'b1;
                    end else begin
                        w_next = S_Q_CMD;
                    end
                end
            end
            S_INIT_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    w_next   = w_empty ? S_IDLE : S_Q_CMD;
                    w_finish = w_empty;
                end
            end
            S_Q_CMD: begin
                cmd_valid               = 1'b1;
                cmd_payload_function_id = FID_QUERY;
                cmd_payload_inputs_0    = w_qx;
                cmd_payload_inputs_1    = w_qy;
                rsp_ready               = 1'b1;
                if (cmd_ready) begin
                    w_capture = rsp_valid;
                    w_next    = rsp_valid ? S_EMIT : S_Q_RSP;
                end
            end
            S_Q_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_EMIT;
                end
            end
            S_EMIT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next    = w_last ? S_IDLE : S_Q_CMD;
                    w_finish  = w_last;
                    w_advance = !w_last;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: the datapath registers are few and feed outputs that must read 0
    // in reset, so all of them take the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xi        <= '0;
            r_yi        <= '0;
            r_cols      <= '0;
            r_rows      <= '0;
            r_box_w     <= '0;
            r_box_h     <= '0;
            r_org_x     <= '0;
            r_org_y     <= '0;
            r_res_in    <= 1'b0;
            r_done      <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_done <= w_finish;
            if (w_start) begin
                r_box_w     <= box_w;
                r_box_h     <= box_h;
                r_org_x     <= org_x;
                r_org_y     <= org_y;
                r_cols      <= cols;
                r_rows      <= rows;
                r_xi        <= '0;
                r_yi        <= '0;
                r_hit_count <= '0;
            end
            if (w_capture) begin
                r_res_in    <= rsp_payload_outputs_0[0];
                r_hit_count <= r_hit_count + (2*CNT_W)'(rsp_payload_outputs_0[0]);
            end
            if (w_advance) begin
                if (w_row_end) begin
                    r_xi <= '0;
                    r_yi <= r_yi + CNT_W'(1);
                end else begin
                    r_xi <= r_xi + CNT_W'(1);
                end
            end
        end
    end

    assign res_x     = w_qx;
    assign res_y     = w_qy;
    assign res_in    = r_res_in;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign hit_count = r_hit_count;

endmodule
